// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
package piso_pkg;

    // Transmitter FSM encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial-side signals of the transmitter.
interface piso_shift_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data_in;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             done;

    // Word source / serial sink side.
    modport master (
        output load_valid, data_in, shift_en,
        input  load_ready, serial_out, serial_valid, busy, done
    );

    // Transmitter side.
    modport slave (
        input  load_valid, data_in, shift_en,
        output load_ready, serial_out, serial_valid, busy, done
    );
endinterface

// File: rtl/shift_reg_en.sv
// WIDTH-bit shift register with parallel load and shift enable.
// head is the bit that leaves the register on the next shift.
module shift_reg_en #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             head
);
    logic [WIDTH-1:0] reg_q;

    // Load wins over shift; with neither asserted the register holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_q <= '0;
        end else if (load) begin
            reg_q <= data;
        end else if (shift) begin
            reg_q <= MSB_FIRST ? {reg_q[WIDTH-2:0], 1'b0} : {1'b0, reg_q[WIDTH-1:1]};
        end
    end

    // Outgoing bit depends on the shift direction.
    always_comb begin
        head = MSB_FIRST ? reg_q[WIDTH-1] : reg_q[0];
    end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: accepts a word over valid/ready,
// shifts it out one bit per enabled clock, then pulses done.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    piso_shift_tx_if.slave  bus
);
    localparam int unsigned CntWidth = cnt_width(WIDTH);

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  armed_q;
    logic                  load;
    logic                  shift;
    logic                  head;

    // Keeps load_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // FSM state and bit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and shift-register controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (armed_q && bus.load_valid) begin
                    state_d = StShift;
                    cnt_d   = CntWidth'(WIDTH - 1);
                    load    = 1'b1;
                end
            end
            StShift: begin
                // shift_en low freezes register, counter and state.
                if (bus.shift_en) begin
                    if (cnt_q != '0) begin
                        shift = 1'b1;
                        cnt_d = cnt_q - CntWidth'(1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    shift_reg_en #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .data  (bus.data_in),
        .head  (head)
    );

    // Outputs decoded from registered state only.
    always_comb begin
        bus.load_ready   = (state_q == StIdle) && armed_q;
        bus.serial_valid = (state_q == StShift);
        bus.serial_out   = (state_q == StShift) && head;
        bus.busy         = (state_q == StShift) || (state_q == StDone);
        bus.done         = (state_q == StDone);
    end

    last_bit_exits: assert property (@(posedge clk) disable iff (!reset)
        (state_q == StShift && cnt_q == '0 && bus.shift_en) |=> (state_q == StDone));

    done_single_cycle: assert property (@(posedge clk) disable iff (!reset)
        (state_q == StDone) |=> (state_q == StIdle));

    stall_holds_count: assert property (@(posedge clk) disable iff (!reset)
        (state_q == StShift && !bus.shift_en) |=> (state_q == StShift && $stable(cnt_q)));

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench: one MSB-first and one LSB-first transmitter driven in lockstep.
module tb_piso_shift_tx;
    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [7:0] data_in;
    logic       shift_en;

    int n_vec;
    int n_err;
    int cyc;
    int accept_cyc;
    int prev_accept;

    piso_shift_tx_if #(.WIDTH(8)) bm ();
    piso_shift_tx_if #(.WIDTH(8)) bl ();

    assign bm.load_valid = load_valid;
    assign bm.data_in    = data_in;
    assign bm.shift_en   = shift_en;
    assign bl.load_valid = load_valid;
    assign bl.data_in    = data_in;
    assign bl.shift_en   = shift_en;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (bm)
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (bl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, expected finished)");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {load_ready, serial_valid, serial_out, busy, done}
    function automatic logic [4:0] st_m();
        return {bm.load_ready, bm.serial_valid, bm.serial_out, bm.busy, bm.done};
    endfunction

    function automatic logic [4:0] st_l();
        return {bl.load_ready, bl.serial_valid, bl.serial_out, bl.busy, bl.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Sends one word from IDLE and checks every serial cycle, done and the return to IDLE.
    task automatic send_word(input logic [7:0] w, input int stall_at, input int stall_len,
                             input bit hold_next, input logic [7:0] next_w, input bit toggle);
        load_valid = 1'b1;
        data_in    = w;
        shift_en   = 1'b1;
        tick();
        prev_accept = accept_cyc;
        accept_cyc  = cyc;
        if (hold_next) begin
            data_in = next_w;
        end else begin
            load_valid = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("bit%0d_m_%0h", i, w), st_m(), {2'b01, w[7-i], 2'b10});
            check_eq($sformatf("bit%0d_l_%0h", i, w), st_l(), {2'b01, w[i], 2'b10});
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    shift_en = 1'b0;
                    if (toggle) data_in = ~data_in;
                    tick();
                    check_eq($sformatf("hold%0d_m", s), st_m(), {2'b01, w[7-i], 2'b10});
                    check_eq($sformatf("hold%0d_l", s), st_l(), {2'b01, w[i], 2'b10});
                end
                shift_en = 1'b1;
            end
            if (toggle) data_in = ~data_in;
            tick();
        end
        check_eq($sformatf("done_m_%0h", w), st_m(), 5'b00011);
        check_eq($sformatf("done_l_%0h", w), st_l(), 5'b00011);
        tick();
        check_eq($sformatf("idle_m_%0h", w), st_m(), 5'b10000);
        check_eq($sformatf("idle_l_%0h", w), st_l(), 5'b10000);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        cyc         = 0;
        accept_cyc  = 0;
        prev_accept = 0;
        reset       = 1'b0;
        load_valid  = 1'b0;
        data_in     = 8'h00;
        shift_en    = 1'b0;

        // Reset state, including load_ready held low.
        #1;
        check_eq("rst_m", st_m(), 5'b00000);
        check_eq("rst_l", st_l(), 5'b00000);
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_clk_m", st_m(), 5'b00000);
        reset = 1'b1;
        #1;
        check_eq("rel_ready_m", st_m(), 5'b00000);
        @(negedge clk);
        tick();
        check_eq("first_idle_m", st_m(), 5'b10000);
        check_eq("first_idle_l", st_l(), 5'b10000);

        // Plain word, both bit orders.
        send_word(8'hA5, -1, 0, 1'b0, 8'h00, 1'b0);

        // Stall three edges while bit 2 is on the line.
        send_word(8'h3C, 2, 3, 1'b0, 8'h00, 1'b0);

        // load_valid held during SHIFT/DONE with a new word; accepted at first IDLE edge.
        send_word(8'hC3, -1, 0, 1'b1, 8'h96, 1'b0);
        send_word(8'h96, -1, 0, 1'b0, 8'h00, 1'b0);
        check_eq("accept_gap", accept_cyc - prev_accept, 10);

        // Reset during the word after bit 4.
        load_valid = 1'b1;
        data_in    = 8'hA5;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("pre_rst_bit%0d_m", i), st_m(), {2'b01, 1'(8'hA5 >> (7 - i)), 2'b10});
            if (i < 4) tick();
        end
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_m", st_m(), 5'b00000);
        check_eq("mid_rst_l", st_l(), 5'b00000);
        @(negedge clk);
        check_eq("mid_rst_edge_m", st_m(), 5'b00000);
        check_eq("mid_rst_edge_l", st_l(), 5'b00000);
        reset = 1'b1;
        #1;
        check_eq("mid_rel_m", st_m(), 5'b00000);
        @(negedge clk);
        tick();
        check_eq("post_rst_idle_m", st_m(), 5'b10000);
        check_eq("post_rst_idle_l", st_l(), 5'b10000);
        send_word(8'hFF, -1, 0, 1'b0, 8'h00, 1'b0);

        // data_in toggling after accept must not disturb the word.
        send_word(8'h81, -1, 0, 1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
